bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter W, default 32: bus and data width.
REQ-002 Parameter NSRC, default 8: number of tri-state bus sources/destinations; max 16.
REQ-003 Parameter SETTLE, default 1: cycles the bus is driven before it is sampled; range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  transfer request; sampled only in IDLE.
REQ-007 src_sel  in  $clog2(NSRC)  index of source to drive the bus.
REQ-008 dst_sel  in  $clog2(NSRC)  index of destination to load.
REQ-009 bus  in  W  shared tri-state data bus.
REQ-010 out_ena  out  NSRC  one-hot source output enables.
REQ-011 in_ena  out  NSRC  one-hot destination load enables.
REQ-012 wdata  out  W  captured bus value, presented to destinations.
REQ-013 busy  out  1  high when state is not IDLE.
REQ-014 done  out  1  one-cycle pulse when a transfer completes.
REQ-015 err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SAMPLE, WRITE and DONE.
REQ-017 IDLE with start=1 and src_sel!=dst_sel: latch both selects, load settle counter with SETTLE-1, go to DRIVE.
REQ-018 IDLE with start=1 and src_sel==dst_sel: pulse err for one cycle next cycle, stay IDLE, assert no enables.
REQ-019 IDLE with start=1 and either select >= NSRC: treat as rejected per REQ-018.
REQ-020 DRIVE: out_ena[src] SHALL be 1; hold while counter !=0 (decrement each cycle); counter==0 -> SAMPLE.
REQ-021 SAMPLE: out_ena[src] SHALL stay 1; wdata register SHALL load bus on the exiting edge; -> WRITE.
REQ-022 WRITE: out_ena SHALL be all-zero; in_ena[dst] SHALL be 1 for exactly one cycle; wdata stable; -> DONE.
REQ-023 DONE: done=1 for one cycle; -> IDLE.
REQ-024 Latency start->done SHALL be SETTLE+3 cycles (SETTLE=1: start cycle 0, done high in cycle 4).
REQ-025 At most one bit of out_ena and one bit of in_ena SHALL be high in any cycle; never both for the same index.
REQ-026 out_ena and in_ena SHALL never be high in the same cycle.
REQ-027 start while busy SHALL be ignored, no err, no queueing.
REQ-028 Changes on src_sel/dst_sel after acceptance SHALL not affect the transfer in flight.
REQ-029 wdata SHALL hold its last captured value until the next SAMPLE.
REQ-030 All outputs SHALL be registered; no combinational path from start or bus to any output.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, out_ena=0, in_ena=0, wdata=0, busy=0, done=0, err=0, counter=0.
REQ-032 Reset asserted mid-transfer SHALL abort it with no in_ena pulse and no done pulse after release.
REQ-033 First start is accepted on the first rising edge with rst_n=1.

Structure
REQ-034 The state encoding enum and the SETTLE/NSRC limits SHALL be in the shared package bus_xfer_pkg.
REQ-035 One sub-module, onehot_dec (index plus enable in, NSRC-bit one-hot out), SHALL generate out_ena and in_ena.

Verification
REQ-036 Transfer: SETTLE=1, src=2 drives 0xDEADBEEF, start with src=2 dst=5 -> out_ena=0x04 in cycles 1-2; in_ena=0x20 and wdata=0xDEADBEEF in cycle 3; done in cycle 4.
REQ-037 Settle: SETTLE=4, src=0 dst=1 -> out_ena=0x01 for 5 cycles; done at cycle 7.
REQ-038 Reject: start with src=dst=3 -> err=1 next cycle; busy, out_ena and in_ena stay 0.
REQ-039 Busy: start again during DRIVE with src=6 -> ignored, exactly one done, in_ena matches the original dst.
REQ-040 Reset: rst_n low during SAMPLE -> all outputs 0 at once; after release no in_ena and no done.
REQ-041 Every test: checker asserts the one-hot and mutual-exclusion rules (REQ-025, REQ-026) on every cycle.

Source files
------------

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types and limits for the tri-state bus transfer controller.
package bus_xfer_pkg;

  localparam int unsigned NSRC_MAX   = 16;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SEL_W      = $clog2(NSRC_MAX) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } xfer_state_e;

  function automatic logic sel_valid(input logic [SEL_W-1:0] idx, input logic [SEL_W-1:0] lim);
    return (idx < lim);
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Handshake and bus signals between the transfer controller and its requester/bus.
interface bus_xfer_ctrl_if #(
  parameter int W    = 32,
  parameter int NSRC = 8
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic            start;
  logic [SW-1:0]   src_sel;
  logic [SW-1:0]   dst_sel;
  logic [W-1:0]    bus;
  logic [NSRC-1:0] out_ena;
  logic [NSRC-1:0] in_ena;
  logic [W-1:0]    wdata;
  logic            busy;
  logic            done;
  logic            err;

  modport slave (
    input  start, src_sel, dst_sel, bus,
    output out_ena, in_ena, wdata, busy, done, err
  );

  modport master (
    output start, src_sel, dst_sel,
    input  out_ena, in_ena, wdata, busy, done, err
  );
endinterface

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index-to-one-hot decoder; out-of-range indices decode to all-zero.
module onehot_dec #(
  parameter int NSRC = 8,
  parameter int SW   = 3
) (
  input  logic [SW-1:0]   idx,
  input  logic            en,
  output logic [NSRC-1:0] onehot
);

  // Decode one enable bit from the index
  always_comb begin
    onehot = '0;
    if (en && (32'(idx) < NSRC)) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Moves one word between tri-state bus sources: drive, settle, sample, write, done.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int W      = 32,
  parameter int NSRC   = 8,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_xfer_ctrl_if.slave  bif
);

  localparam int SW       = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int SETTLE_C = (SETTLE > int'(SETTLE_MAX)) ? int'(SETTLE_MAX) : ((SETTLE < 1) ? 1 : SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_C - 1);

  xfer_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [SW-1:0]    src_r, dst_r, src_nxt_s, dst_nxt_s;
  logic             reject_s, out_en_s, in_en_s;
  logic [NSRC-1:0]  out_dec_s, in_dec_s, out_ena_r, in_ena_r;
  logic [W-1:0]     wdata_r;
  logic             busy_r, done_r, err_r;

  // Next-state, counter and select-latch logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bif.start) begin
          if (sel_valid(SEL_W'(bif.src_sel), SEL_W'(NSRC)) &&
              sel_valid(SEL_W'(bif.dst_sel), SEL_W'(NSRC)) &&
              (bif.src_sel != bif.dst_sel)) begin
            state_nxt_s = ST_DRIVE;
            cnt_nxt_s   = SETTLE_LOAD;
            src_nxt_s   = bif.src_sel;
            dst_nxt_s   = bif.dst_sel;
          end else begin
            reject_s    = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SAMPLE: state_nxt_s = ST_WRITE;
      ST_WRITE:  state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
    out_en_s = (state_nxt_s == ST_DRIVE) || (state_nxt_s == ST_SAMPLE);
    in_en_s  = (state_nxt_s == ST_WRITE);
  end

  // Enables are decoded from the next state so they can be registered
  onehot_dec #(.NSRC(NSRC), .SW(SW)) u_out_dec (.idx(src_nxt_s), .en(out_en_s), .onehot(out_dec_s));
  onehot_dec #(.NSRC(NSRC), .SW(SW)) u_in_dec  (.idx(dst_nxt_s), .en(in_en_s),  .onehot(in_dec_s));

  // FSM state, settle counter and latched selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      src_r   <= {SW{1'b0}};
      dst_r   <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      src_r   <= src_nxt_s;
      dst_r   <= dst_nxt_s;
    end
  end

  // Registered outputs; wdata only loads on the edge leaving SAMPLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ena_r <= {NSRC{1'b0}};
      in_ena_r  <= {NSRC{1'b0}};
      wdata_r   <= {W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      out_ena_r <= out_dec_s;
      in_ena_r  <= in_dec_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      done_r    <= (state_nxt_s == ST_DONE);
      err_r     <= reject_s;
      if (state_r == ST_SAMPLE) begin
        wdata_r <= bif.bus;
      end else begin
        wdata_r <= wdata_r;
      end
    end
  end

  assign bif.out_ena = out_ena_r;
  assign bif.in_ena  = in_ena_r;
  assign bif.wdata   = wdata_r;
  assign bif.busy    = busy_r;
  assign bif.done    = done_r;
  assign bif.err     = err_r;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with SETTLE=1 and SETTLE=4 instances.
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  bus_xfer_ctrl_if #(.W(32), .NSRC(8)) if1 ();
  bus_xfer_ctrl_if #(.W(32), .NSRC(8)) if4 ();

  bus_xfer_ctrl #(.W(32), .NSRC(8), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bif(if1.slave));
  bus_xfer_ctrl #(.W(32), .NSRC(8), .SETTLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bif(if4.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] srcval(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return {16'hA5A5, i[15:0]};
  endfunction

  // Each source drives its own pattern while enabled
  always_comb begin
    if1.bus = 'z;
    for (int i = 0; i < 8; i++) begin
      if (if1.out_ena[i]) if1.bus = srcval(i);
    end
  end

  always_comb begin
    if4.bus = 'z;
    for (int j = 0; j < 8; j++) begin
      if (if4.out_ena[j]) if4.bus = srcval(j);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rules();
    chk("onehot_out1", 64'($onehot0(if1.out_ena)), 64'd1);
    chk("onehot_in1",  64'($onehot0(if1.in_ena)),  64'd1);
    chk("mutex1",      64'((|if1.out_ena) & (|if1.in_ena)), 64'd0);
    chk("onehot_out4", 64'($onehot0(if4.out_ena)), 64'd1);
    chk("onehot_in4",  64'($onehot0(if4.in_ena)),  64'd1);
    chk("mutex4",      64'((|if4.out_ena) & (|if4.in_ena)), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_rules();
  endtask

  initial begin
    logic [7:0] in_seen;
    int         ndone;

    if1.start = 1'b0; if1.src_sel = 3'd0; if1.dst_sel = 3'd0;
    if4.start = 1'b0; if4.src_sel = 3'd0; if4.dst_sel = 3'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out",   64'(if1.out_ena), 64'h0);
    chk("rst_in",    64'(if1.in_ena),  64'h0);
    chk("rst_wdata", 64'(if1.wdata),   64'h0);
    chk("rst_busy",  64'(if1.busy),    64'h0);
    chk("rst_done",  64'(if1.done),    64'h0);
    chk("rst_err",   64'(if1.err),     64'h0);
    chk("rst_busy4", 64'(if4.busy),    64'h0);

    // Basic transfer, start presented on the first edge after release
    @(posedge clk); #1;
    rst_n = 1'b1;
    if1.start = 1'b1; if1.src_sel = 3'd2; if1.dst_sel = 3'd5;
    tick(); if1.start = 1'b0;
    chk("xf_c1_out",  64'(if1.out_ena), 64'h04);
    chk("xf_c1_in",   64'(if1.in_ena),  64'h00);
    chk("xf_c1_busy", 64'(if1.busy),    64'h1);
    tick();
    chk("xf_c2_out",  64'(if1.out_ena), 64'h04);
    chk("xf_c2_done", 64'(if1.done),    64'h0);
    tick();
    chk("xf_c3_out",  64'(if1.out_ena), 64'h00);
    chk("xf_c3_in",   64'(if1.in_ena),  64'h20);
    chk("xf_c3_wd",   64'(if1.wdata),   64'hDEADBEEF);
    chk("xf_c3_done", 64'(if1.done),    64'h0);
    tick();
    chk("xf_c4_done", 64'(if1.done),    64'h1);
    chk("xf_c4_in",   64'(if1.in_ena),  64'h00);
    chk("xf_c4_busy", 64'(if1.busy),    64'h1);
    tick();
    chk("xf_c5_done", 64'(if1.done),    64'h0);
    chk("xf_c5_busy", 64'(if1.busy),    64'h0);
    chk("xf_c5_wd",   64'(if1.wdata),   64'hDEADBEEF);

    // Reject: identical source and destination
    if1.start = 1'b1; if1.src_sel = 3'd3; if1.dst_sel = 3'd3;
    tick(); if1.start = 1'b0;
    chk("rej_err",  64'(if1.err),     64'h1);
    chk("rej_busy", 64'(if1.busy),    64'h0);
    chk("rej_out",  64'(if1.out_ena), 64'h00);
    chk("rej_in",   64'(if1.in_ena),  64'h00);
    tick();
    chk("rej_err2", 64'(if1.err),     64'h0);
    chk("rej_busy2",64'(if1.busy),    64'h0);
    chk("rej_wd",   64'(if1.wdata),   64'hDEADBEEF);

    // Start while busy is ignored; selects change mid-flight
    if1.start = 1'b1; if1.src_sel = 3'd1; if1.dst_sel = 3'd4;
    tick();
    if1.src_sel = 3'd6; if1.dst_sel = 3'd7;
    tick(); if1.start = 1'b0;
    chk("bsy_out",  64'(if1.out_ena), 64'h02);
    chk("bsy_err",  64'(if1.err),     64'h0);
    ndone = 0; in_seen = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if1.done) ndone++;
      in_seen = in_seen | if1.in_ena;
    end
    chk("bsy_ndone", 64'(ndone),      64'd1);
    chk("bsy_in",    64'(in_seen),    64'h10);
    chk("bsy_wd",    64'(if1.wdata),  64'hA5A50001);
    chk("bsy_idle",  64'(if1.busy),   64'h0);

    // Longer settle on the SETTLE=4 instance
    if4.start = 1'b1; if4.src_sel = 3'd0; if4.dst_sel = 3'd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) if4.start = 1'b0;
      chk($sformatf("set_out_c%0d", c),  64'(if4.out_ena), (c <= 5) ? 64'h01 : 64'h00);
      chk($sformatf("set_in_c%0d", c),   64'(if4.in_ena),  (c == 6) ? 64'h02 : 64'h00);
      chk($sformatf("set_done_c%0d", c), 64'(if4.done),    (c == 7) ? 64'h1 : 64'h0);
    end
    chk("set_wd", 64'(if4.wdata), 64'hA5A50000);

    // Reset during SAMPLE aborts the transfer
    if1.start = 1'b1; if1.src_sel = 3'd2; if1.dst_sel = 3'd5;
    tick(); if1.start = 1'b0;
    tick();
    chk("ar_c2_out", 64'(if1.out_ena), 64'h04);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out",  64'(if1.out_ena), 64'h00);
    chk("ar_in",   64'(if1.in_ena),  64'h00);
    chk("ar_wd",   64'(if1.wdata),   64'h0);
    chk("ar_busy", 64'(if1.busy),    64'h0);
    chk("ar_done", 64'(if1.done),    64'h0);
    chk("ar_err",  64'(if1.err),     64'h0);
    tick();
    rst_n = 1'b1;
    ndone = 0; in_seen = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if1.done) ndone++;
      in_seen = in_seen | if1.in_ena;
    end
    chk("ar_post_done", 64'(ndone),     64'd0);
    chk("ar_post_in",   64'(in_seen),   64'h00);
    chk("ar_post_busy", 64'(if1.busy),  64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
